// File: rtl/dso_capture_ctrl.sv
// rtl/dso_capture_ctrl.sv - acquisition sequencer for the double-banked DSO sample memory
//
// Arms on command, fills a 2048-sample ring in the active bank, holds a
// programmable pretrigger depth, detects a level/edge trigger on one 8-bit
// channel, counts post-trigger samples, then publishes the finished bank
// to the readout side and swaps banks.
//
// Optional feature macro: AUTO_TRIG_EN (auto trigger after AUTO_TIMEOUT
// sample strobes spent waiting in WAIT with auto_en set).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   sample_en         one-cycle strobe, adc_data valid
//   adc_data[15:0]    channel B [15:8], channel A [7:0]
//   arm, abort, cont  start capture, return to IDLE, rearm after publish
//   pretrig[10:0]     pretrigger depth (latched on arm)
//   trig_level[7:0]   trigger threshold (latched on arm)
//   trig_edge         0 rising, 1 falling (latched on arm)
//   trig_ch           0 channel A, 1 channel B (latched on arm)
//   auto_en           enables auto trigger
//   rd_busy           readout still draining the published bank
//   mem_we/mem_addr/mem_wdata   registered sample memory write port
//   update_flag       one-cycle publish pulse
//   write_addr[11:0]  {published bank, oldest sample address}
//   state[2:0]        IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4
//   trig_auto         last capture was force-triggered

module dso_capture_ctrl #(
   parameter logic [19:0] AUTO_TIMEOUT = 20'd1000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_en,
   input  logic [15:0] adc_data,
   input  logic        arm,
   input  logic        abort,
   input  logic        cont,
   input  logic [10:0] pretrig,
   input  logic [7:0]  trig_level,
   input  logic        trig_edge,
   input  logic        trig_ch,
   input  logic        auto_en,
   input  logic        rd_busy,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        update_flag,
   output logic [11:0] write_addr,
   output logic [2:0]  state,
   output logic        trig_auto
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        bank;
   logic [10:0] ring_ptr;
   logic [10:0] pre_ctr;
   logic [11:0] post_ctr;
   logic [7:0]  prev;
   logic        prev_valid;

   logic [10:0] pretrig_q;
   logic [7:0]  level_q;
   logic        edge_q;
   logic        ch_q;

   logic [7:0]  cur;
   logic        edge_hit;
   logic        auto_hit;
   logic [11:0] post_first;

   logic        do_write;
   logic        do_trig;
   logic        do_publish;
   logic        do_arm;
   logic        do_rearm;
   logic        wr_bank;

   assign state = state_q;
   assign cur   = ch_q ? adc_data[15:8] : adc_data[7:0];

   assign edge_hit = prev_valid &&
                     (edge_q ? (prev >= level_q && cur <  level_q)
                             : (prev <  level_q && cur >= level_q));

   // Post window is 2048 - pretrig samples, and the triggering sample is
   // already the first of them, so this is what remains after it.
   assign post_first = 12'd2047 - {1'b0, pretrig_q};

   // A sample taken in the publish cycle of a rearm belongs to the new bank.
   assign wr_bank = bank ^ do_publish;

`ifdef AUTO_TRIG_EN
   logic [19:0] auto_ctr;
   logic        trig_auto_q;

   assign auto_hit  = auto_en && (auto_ctr + 20'd1 == AUTO_TIMEOUT);
   assign trig_auto = trig_auto_q;

   // Counter only runs inside WAIT, so it is zero on every entry to WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_ctr <= 20'd0;
      end else if (state_q != S_WAIT) begin
         auto_ctr <= 20'd0;
      end else if (sample_en && auto_en) begin
         auto_ctr <= auto_ctr + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trig_auto_q <= 1'b0;
      end else if (do_arm || do_rearm) begin
         trig_auto_q <= 1'b0;
      end else if (do_trig) begin
         trig_auto_q <= auto_hit && !edge_hit;
      end
   end
`else
   logic unused_auto;

   assign auto_hit    = 1'b0;
   assign trig_auto   = 1'b0;
   assign unused_auto = auto_en ^ (AUTO_TIMEOUT == 20'd0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      do_write   = 1'b0;
      do_trig    = 1'b0;
      do_publish = 1'b0;
      do_arm     = 1'b0;
      do_rearm   = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  do_arm  = 1'b1;
                  state_d = (pretrig == 11'd0) ? S_WAIT : S_PRE;
               end
            end
            S_PRE: begin
               if (sample_en) begin
                  do_write = 1'b1;
                  if (pre_ctr + 11'd1 == pretrig_q) begin
                     state_d = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (sample_en) begin
                  do_write = 1'b1;
                  if (edge_hit || auto_hit) begin
                     do_trig = 1'b1;
                     state_d = (post_first == 12'd0) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (sample_en) begin
                  do_write = 1'b1;
                  if (post_ctr == 12'd1) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!rd_busy) begin
                  do_publish = 1'b1;
                  if (cont) begin
                     // Rearm; a sample arriving now is the first PRE sample.
                     do_rearm = 1'b1;
                     do_write = sample_en;
                     state_d  = (pretrig_q == 11'd0 ||
                                 (sample_en && pretrig_q == 11'd1)) ? S_WAIT : S_PRE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank        <= 1'b0;
         ring_ptr    <= 11'd0;
         pre_ctr     <= 11'd0;
         post_ctr    <= 12'd0;
         prev        <= 8'd0;
         prev_valid  <= 1'b0;
         pretrig_q   <= 11'd0;
         level_q     <= 8'd0;
         edge_q      <= 1'b0;
         ch_q        <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 12'd0;
         mem_wdata   <= 16'd0;
         update_flag <= 1'b0;
         write_addr  <= 12'd0;
      end else begin
         mem_we      <= do_write;
         update_flag <= do_publish;

         if (do_write) begin
            mem_addr  <= {wr_bank, ring_ptr};
            mem_wdata <= adc_data;
            ring_ptr  <= ring_ptr + 11'd1;
            prev      <= cur;
         end

         if (do_arm) begin
            pretrig_q <= pretrig;
            level_q   <= trig_level;
            edge_q    <= trig_edge;
            ch_q      <= trig_ch;
         end

         if (do_arm) begin
            prev_valid <= 1'b0;
         end else if (do_rearm) begin
            prev_valid <= sample_en;
         end else if (do_write) begin
            prev_valid <= 1'b1;
         end

         if (do_arm) begin
            pre_ctr <= 11'd0;
         end else if (do_rearm) begin
            pre_ctr <= sample_en ? 11'd1 : 11'd0;
         end else if (state_q == S_PRE && do_write) begin
            pre_ctr <= pre_ctr + 11'd1;
         end

         if (do_trig) begin
            post_ctr <= post_first;
         end else if (state_q == S_POST && do_write) begin
            post_ctr <= post_ctr - 12'd1;
         end

         // ring_ptr here is the slot after the newest sample, i.e. the oldest.
         if (do_publish) begin
            write_addr <= {bank, ring_ptr};
            bank       <= ~bank;
         end
      end
   end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// tb/tb_dso_capture_ctrl.sv - self-checking bench for dso_capture_ctrl

module tb_dso_capture_ctrl;

   localparam int NS = 5000;

   logic        clk;
   logic        reset_n;
   logic        sample_en;
   logic [15:0] adc_data;
   logic        arm;
   logic        abort;
   logic        cont;
   logic [10:0] pretrig;
   logic [7:0]  trig_level;
   logic        trig_edge;
   logic        trig_ch;
   logic        auto_en;
   logic        rd_busy;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        update_flag;
   logic [11:0] write_addr;
   logic [2:0]  state;
   logic        trig_auto;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] stream [NS];
   int          ptr_m;
   logic        bank_m;

   typedef struct {
      int pre;
      int lvl;
      bit edg;
      bit chs;
      int pat;
      int preptr;
      int busy;
      bit cnt;
      int trig;
      int waddr;
   } vec_t;

   vec_t tbl [8];

   dso_capture_ctrl #(.AUTO_TIMEOUT(20'd16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_en   (sample_en),
      .adc_data    (adc_data),
      .arm         (arm),
      .abort       (abort),
      .cont        (cont),
      .pretrig     (pretrig),
      .trig_level  (trig_level),
      .trig_edge   (trig_edge),
      .trig_ch     (trig_ch),
      .auto_en     (auto_en),
      .rd_busy     (rd_busy),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .update_flag (update_flag),
      .write_addr  (write_addr),
      .state       (state),
      .trig_auto   (trig_auto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      reset_n = 1'b0; sample_en = 1'b0; adc_data = 16'd0; arm = 1'b0; abort = 1'b0;
      cont = 1'b0; pretrig = 11'd0; trig_level = 8'd0; trig_edge = 1'b0; trig_ch = 1'b0;
      auto_en = 1'b0; rd_busy = 1'b0;
      repeat (3) tick;
      reset_n = 1'b1;
      tick;
      ptr_m  = 0;
      bank_m = 1'b0;
   endtask

   // Move the ring pointer by parking in a deep PRE, then aborting.
   task automatic pre_advance(input int n);
      pretrig = 11'd2047;
      arm = 1'b1; tick; arm = 1'b0;
      for (int k = 0; k < n; k++) begin
         sample_en = 1'b1; adc_data = 16'($urandom); tick; sample_en = 1'b0;
      end
      abort = 1'b1; tick; abort = 1'b0;
      check("preadv_idle", state, 0);
      ptr_m = n % 2048;
   endtask

   function automatic logic [7:0] sel(input logic [15:0] d, input bit chs);
      return chs ? d[15:8] : d[7:0];
   endfunction

   // Reference trigger search straight from the trigger rules.
   function automatic int find_trig(input int pre, input logic [7:0] lvl, input bit edg, input bit chs);
      for (int k = (pre > 0) ? pre : 1; k < NS; k++) begin
         logic [7:0] p;
         logic [7:0] c;
         p = sel(stream[k-1], chs);
         c = sel(stream[k], chs);
         if (!edg && p < lvl && c >= lvl) return k;
         if (edg && p >= lvl && c < lvl) return k;
      end
      return -1;
   endfunction

   task automatic gen_stream(input int pat, input bit chs);
      for (int k = 0; k < NS; k++) begin
         logic [7:0] v;
         logic [7:0] r;
         r = 8'($urandom);
         case (pat)
            0: v = 8'(k % 256);
            1: v = 8'(255 - (k % 256));
            2: begin v = 8'h20; r = 8'h20; end
            default: v = 8'($urandom);
         endcase
         stream[k] = chs ? {v, r} : {r, v};
      end
   endtask

   task automatic run_capture(input int pre, input int lvl, input bit edg, input bit chs,
                              input int pat, input int busy, input bit cnt, input bit do_arm,
                              input int exp_trig, input int exp_waddr, input string tag);
      int trig, last, wbad, sbad, pbad, obs_trig, es;
      string wmsg, smsg;
      logic [11:0] eaddr, ew;
      gen_stream(pat, chs);
      trig = (exp_trig >= 0) ? exp_trig : find_trig(pre, 8'(lvl), edg, chs);
      if (trig < 0) begin
         n_assert++; n_fail++;
         $display("FAIL %s_model: no trigger in stimulus, got -1, expected >=0", tag);
         return;
      end
      last = trig + (2048 - pre) - 1;
      pretrig = 11'(pre); trig_level = 8'(lvl); trig_edge = edg; trig_ch = chs;
      cont = cnt; rd_busy = 1'b0;
      if (do_arm) begin
         arm = 1'b1; tick; arm = 1'b0;
         check($sformatf("%s_arm_state", tag), state, (pre == 0) ? 2 : 1);
      end
      wbad = 0; sbad = 0; obs_trig = -1; wmsg = ""; smsg = "";
      for (int k = 0; k <= last; k++) begin
         if (k == last) rd_busy = (busy > 0);
         sample_en = 1'b1; adc_data = stream[k]; tick; sample_en = 1'b0;
         eaddr = {bank_m, 11'((ptr_m + k) % 2048)};
         if (mem_we !== 1'b1 || mem_addr !== eaddr || mem_wdata !== stream[k]) begin
            if (wbad == 0) wmsg = $sformatf("k=%0d we=%0b addr=%0h/%0h data=%0h/%0h",
                                            k, mem_we, mem_addr, eaddr, mem_wdata, stream[k]);
            wbad++;
         end
         if (k >= trig) es = (k == last) ? 4 : 3;
         else           es = (k + 1 < pre) ? 1 : 2;
         if (state !== 3'(es)) begin
            if (sbad == 0) smsg = $sformatf("k=%0d state=%0d/%0d", k, state, es);
            sbad++;
         end
         if (obs_trig < 0 && (state == 3'd3 || state == 3'd4)) obs_trig = k;
         if (pat == 3 && k != last && $urandom_range(0, 3) == 0) begin
            tick;
            if (mem_we !== 1'b0) wbad++;
         end
      end
      n_assert++;
      if (wbad != 0) begin
         n_fail++;
         $display("FAIL %s_writes: %0d bad, first (got/expected) %s", tag, wbad, wmsg);
      end
      n_assert++;
      if (sbad != 0) begin
         n_fail++;
         $display("FAIL %s_states: %0d bad, first (got/expected) %s", tag, sbad, smsg);
      end
      check($sformatf("%s_trig_index", tag), obs_trig, trig);
      ptr_m = (ptr_m + last + 1) % 2048;
      pbad = 0;
      repeat (busy) begin
         tick;
         if (update_flag !== 1'b0 || state !== 3'd4) pbad++;
      end
      if (busy > 0) check($sformatf("%s_busy_hold", tag), pbad, 0);
      rd_busy = 1'b0;
      tick;
      ew = (exp_waddr >= 0) ? 12'(exp_waddr) : {bank_m, 11'(ptr_m)};
      check($sformatf("%s_update_flag", tag), update_flag, 1);
      check($sformatf("%s_write_addr", tag), write_addr, ew);
      check($sformatf("%s_after_pub", tag), state, cnt ? ((pre == 0) ? 2 : 1) : 0);
      bank_m = ~bank_m;
      tick;
      check($sformatf("%s_pulse_end", tag), update_flag, 0);
      check($sformatf("%s_addr_hold", tag), write_addr, ew);
   endtask

   initial begin
      tbl[0] = '{100,  'h80, 1'b0, 1'b0, 0, 0,    0,  1'b0, 128,  'h01C};
      tbl[1] = '{0,    'h10, 1'b0, 1'b0, 0, 0,    0,  1'b0, 16,   'h010};
      tbl[2] = '{2047, 'h05, 1'b0, 1'b0, 0, 0,    0,  1'b0, 2053, 'h006};
      tbl[3] = '{10,   'h40, 1'b1, 1'b1, 1, 2040, 0,  1'b0, 192,  'h0AE};
      tbl[4] = '{100,  'h80, 1'b0, 1'b0, 0, 0,    50, 1'b1, 128,  'h01C};
      for (int i = 5; i < 8; i++) begin
         tbl[i] = '{int'($urandom_range(0, 2047)), int'($urandom_range(32, 224)),
                    1'($urandom), 1'($urandom), 3, int'($urandom_range(0, 500)),
                    int'($urandom_range(0, 5)), 1'b0, -1, -1};
      end

      do_reset;
      check("rst_state", state, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_update_flag", update_flag, 0);
      check("rst_write_addr", write_addr, 0);
      check("rst_trig_auto", trig_auto, 0);

      for (int i = 0; i < 8; i++) begin
         do_reset;
         if (tbl[i].preptr > 0) pre_advance(tbl[i].preptr);
         run_capture(tbl[i].pre, tbl[i].lvl, tbl[i].edg, tbl[i].chs, tbl[i].pat,
                     tbl[i].busy, tbl[i].cnt, 1'b1, tbl[i].trig, tbl[i].waddr,
                     $sformatf("v%0d", i));
         if (i == 4) run_capture(100, 'h80, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 128, 'h838, "v4_cont");
      end
      check("no_auto_flag", trig_auto, 0);

      // abort racing a trigger, arm outside IDLE, abort beating arm
      do_reset;
      pretrig = 11'd2; trig_level = 8'h80; trig_edge = 1'b0; trig_ch = 1'b0;
      arm = 1'b1; tick; arm = 1'b0;
      check("ab_pre", state, 1);
      sample_en = 1'b1; adc_data = 16'h0010; tick;
      adc_data = 16'h0020; tick; sample_en = 1'b0;
      check("ab_wait", state, 2);
      pretrig = 11'd0; arm = 1'b1; tick; arm = 1'b0;
      check("ab_arm_ignored", state, 2);
      sample_en = 1'b1; adc_data = 16'h0090; abort = 1'b1; tick;
      sample_en = 1'b0; abort = 1'b0;
      check("ab_idle", state, 0);
      check("ab_no_write", mem_we, 0);
      tick;
      check("ab_no_publish", update_flag, 0);
      arm = 1'b1; abort = 1'b1; tick; arm = 1'b0; abort = 1'b0;
      check("ab_beats_arm", state, 0);
      pretrig = 11'd5; arm = 1'b1; tick; arm = 1'b0;
      check("ab_rearm", state, 1);
      sample_en = 1'b1; adc_data = 16'h0011; tick; sample_en = 1'b0;
      check("ab_bank_ptr", mem_addr, 12'h002);
      abort = 1'b1; tick; abort = 1'b0;

`ifdef AUTO_TRIG_EN
      do_reset;
      auto_en = 1'b1;
      run_capture(0, 'h80, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 15, 'h00F, "auto");
      check("auto_flag", trig_auto, 1);
      auto_en = 1'b0;
`else
      begin
         int sbad;
         do_reset;
         auto_en = 1'b1; pretrig = 11'd0; trig_level = 8'h80;
         arm = 1'b1; tick; arm = 1'b0;
         sbad = 0;
         for (int k = 0; k < 300; k++) begin
            sample_en = 1'b1; adc_data = 16'h2020; tick; sample_en = 1'b0;
            if (state !== 3'd2) sbad++;
         end
         check("noauto_stays_wait", sbad, 0);
         check("noauto_flag", trig_auto, 0);
         abort = 1'b1; tick; abort = 1'b0;
         auto_en = 1'b0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dso_capture_ctrl.md
# dso_capture_ctrl

Sequences acquisition into the 4096×16 double-banked sample memory that the SPI readout path drains. The block arms on command and fills a 2048-sample ring in the active bank. It enforces a programmable pretrigger depth, detects a level/edge trigger on one 8-bit channel, and counts post-trigger samples. It then publishes the finished bank to the readout side via `update_flag`/`write_addr` and swaps banks.

## Interface
- `AUTO_TIMEOUT`, default 20'd1000000: sample strobes spent waiting for a trigger before an auto trigger fires. Used only with `AUTO_TRIG_EN`.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_en` in 1: one-cycle strobe; `adc_data` is valid in this cycle.
- `adc_data` in 16: channel B on [15:8], channel A on [7:0].
- `arm` in 1: pulse that starts a capture.
- `abort` in 1: pulse that returns the block to IDLE without publishing.
- `cont` in 1: rearm automatically after each publish.
- `pretrig` in 11: samples kept before the trigger; latched on arm.
- `trig_level` in 8: trigger threshold; latched on arm.
- `trig_edge` in 1: 0 = rising, 1 = falling; latched on arm.
- `trig_ch` in 1: 0 = channel A, 1 = channel B; latched on arm.
- `auto_en` in 1: enables auto trigger.
- `rd_busy` in 1: readout is currently draining the published bank.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 12: write address, {bank, ring_ptr[10:0]}.
- `mem_wdata` out 16: registered copy of `adc_data`.
- `update_flag` out 1: one-cycle publish pulse.
- `write_addr` out 12: {published bank, oldest-sample address}; valid when `update_flag` is high.
- `state` out 3: current state encoding.
- `trig_auto` out 1: the last capture was force-triggered.

## Operation
- States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- IDLE:
  - On `arm`, latch the config and clear `pre_ctr`, `prev_valid` and `trig_auto`.
  - Go to PRE, or to WAIT if `pretrig`==0.
- All states except IDLE and DONE:
  - Every `sample_en` writes `adc_data` to {bank, ring_ptr}, then increments ring_ptr (11-bit, wraps 2047→0).
- PRE: count samples; after the `pretrig`-th sample go to WAIT. The trigger is ignored in PRE.
- WAIT:
  - Selected byte `cur` and previous sample `prev` (valid only after the first sample since arm).
  - Rising trigger: `prev_valid` && `prev`<`trig_level` && `cur`>=`trig_level`.
  - Falling trigger: `prev_valid` && `prev`>=`trig_level` && `cur`<`trig_level`.
  - The triggering sample is written and counts as post sample 1. Load `post_ctr` = 2048−`pretrig` (12-bit, range 1..2048), then go to POST, or straight to DONE if `post_ctr` reaches 0 on that sample.
- POST: decrement `post_ctr` per written sample; the sample that reaches 0 moves the block to DONE.
- DONE:
  - Writes stop.
  - While `rd_busy`=1, hold and do not publish.
  - When `rd_busy`=0, pulse `update_flag` with `write_addr`={bank, ring_ptr}. This is the oldest sample, because the window is exactly 2048 samples.
  - Toggle bank. Go to PRE/WAIT (re-arm with the held config) if `cont`, else IDLE.
- `abort` in any state: go to IDLE, no publish, bank unchanged; wins over `arm` and over every other event in the same cycle.
- `arm` outside IDLE is ignored.
- Reset: `state`=IDLE, bank=0, ring_ptr=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `update_flag`=0, `write_addr`=0, `trig_auto`=0.

## Timing
- `mem_we`, `mem_addr` and `mem_wdata` are registered: the write appears 1 cycle after `sample_en`, and `mem_we` is high for exactly 1 cycle.
- The state transition caused by a sample takes effect in the same cycle the write registers (1 cycle after `sample_en`).
- `update_flag` asserts 1 cycle after DONE is entered with `rd_busy`=0, or 1 cycle after `rd_busy` falls.
- `write_addr` holds its value until the next publish.
- A `sample_en` in the publish cycle is dropped if the block goes to IDLE, and written to the new bank if it re-arms.
- `reset_n` deassertion mid-capture discards the capture; no publish.

## Configuration
- `AUTO_TRIG_EN` defined:
  - In WAIT with `auto_en`=1, a 20-bit counter counts `sample_en`.
  - On reaching `AUTO_TIMEOUT`, the current sample is treated as the trigger and `trig_auto` is set.
  - The counter clears on entering WAIT.
- `AUTO_TRIG_EN` undefined: no counter is built, `auto_en` is ignored, and `trig_auto` is tied 0.

## Test plan
- Pretrig 100, rising, level 0x80, ramp 0x00..0xFF on channel A:
  - Trigger occurs at the first sample ≥0x80 after PRE ends, then 1948 post writes and `update_flag`.
  - `write_addr`[10:0] is the address just after the last write, and bank 0 is published.
- `pretrig`=0: PRE is skipped. `pretrig`=2047: exactly 1 post sample, so the block goes directly to DONE.
- `rd_busy` held high for 50 cycles at DONE: no `update_flag` until 1 cycle after `rd_busy` falls; `cont`=1 then re-arms in bank 1.
- `abort` asserted together with a trigger in WAIT: the block returns to IDLE, no publish, bank unchanged.
- Falling edge on channel B with ring_ptr starting at 2040: addresses wrap 2047→0 and `mem_addr`[11] stays constant.
- With `AUTO_TRIG_EN`, `AUTO_TIMEOUT`=16, constant input: the trigger fires on the 16th WAIT sample, `trig_auto`=1 and the capture is published. Without the macro, the block stays in WAIT indefinitely.
